// File: rtl/wb_bus_guard.sv
// Registered Wishbone pipeline guard: skid-buffered request path, outstanding
// request accounting, and bus-error return on slave error or slave timeout.
module wb_bus_guard #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LGDEPTH = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_cyc,
  input  logic            i_stb,
  input  logic            i_we,
  input  logic [AW-1:0]   i_adr,
  input  logic [DW-1:0]   i_dat,
  input  logic [DW/8-1:0] i_sel,
  output logic            o_ack,
  output logic            o_stall,
  output logic            o_err,
  output logic [DW-1:0]   o_data,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_adr,
  output logic [DW-1:0]   o_wb_dat,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_ack,
  input  logic            i_wb_stall,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data
);
  localparam int SW = DW/8;
  localparam int TW = $clog2(TIMEOUT+1);
  localparam logic [LGDEPTH-1:0] MAXOUT = '1;
  localparam logic [TW-1:0]      TMAX   = TW'(TIMEOUT);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } req_t;

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t             state_q, state_d;
  req_t               out_q, out_d, skid_q, skid_d, in_req;
  logic               stb_q, stb_d, skid_v_q, skid_v_d, cyc_q, cyc_d;
  logic               ack_q, ack_d, err_q, err_d, stall_q, stall_d;
  logic [DW-1:0]      data_q, data_d;
  logic [LGDEPTH-1:0] npend_q, npend_d;
  logic [TW-1:0]      timer_q, timer_d, timer_inc;
  logic               accept, counting, timeout, fault, ack_fwd;

  assign in_req   = {i_we, i_adr, i_dat, i_sel};
  assign accept   = i_cyc && i_stb && !stall_q;
  assign counting = (state_q == BUSY) && (stb_q || npend_q != '0);
  // timer_inc includes the current idle cycle, so the abort lands TIMEOUT clocks after issue
  assign timer_inc = (counting && timer_q != TMAX) ? timer_q + TW'(1) : timer_q;
  assign timeout   = counting && (timer_inc == TMAX) && !i_wb_ack;
  assign fault     = i_wb_err || timeout;
  assign ack_fwd   = i_wb_ack && (npend_q != '0) && !i_wb_err;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (!i_cyc) state_d = IDLE;
               else if (fault) state_d = ABORT;
      ABORT:   if (!i_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_d    = out_q;
    skid_d   = skid_q;
    stb_d    = stb_q;
    skid_v_d = skid_v_q;
    npend_d  = npend_q;
    timer_d  = timer_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    data_d   = i_wb_ack ? i_wb_data : data_q;
    if (state_d == BUSY) begin
      if (!stb_q || !i_wb_stall) begin
        if (skid_v_q) begin
          out_d    = skid_q;
          skid_v_d = 1'b0;
        end else if (accept) begin
          out_d = in_req;
          stb_d = 1'b1;
        end else begin
          stb_d = 1'b0;
        end
      end else if (accept) begin
        skid_d   = in_req;
        skid_v_d = 1'b1;
      end
      ack_d   = (state_q == BUSY) && ack_fwd;
      npend_d = npend_q + LGDEPTH'(accept) - LGDEPTH'(ack_d);
      timer_d = i_wb_ack ? '0 : timer_inc;
    end else begin
      // leaving BUSY (or not in it) drops everything in flight
      stb_d    = 1'b0;
      skid_v_d = 1'b0;
      npend_d  = '0;
      timer_d  = '0;
      err_d    = ((state_q == BUSY) && i_cyc && fault) ||
                 ((state_q == ABORT) && i_cyc && i_stb);
    end
    cyc_d   = (state_d == BUSY);
    stall_d = (state_d == BUSY) && (skid_v_d || npend_d == MAXOUT);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      out_q    <= '0;
      skid_q   <= '0;
      stb_q    <= 1'b0;
      skid_v_q <= 1'b0;
      cyc_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      stall_q  <= 1'b0;
      data_q   <= '0;
      npend_q  <= '0;
      timer_q  <= '0;
    end else begin
      out_q    <= out_d;
      skid_q   <= skid_d;
      stb_q    <= stb_d;
      skid_v_q <= skid_v_d;
      cyc_q    <= cyc_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      stall_q  <= stall_d;
      data_q   <= data_d;
      npend_q  <= npend_d;
      timer_q  <= timer_d;
    end
  end

  assign o_ack    = ack_q;
  assign o_err    = err_q;
  assign o_stall  = stall_q;
  assign o_data   = data_q;
  assign o_wb_cyc = cyc_q;
  assign o_wb_stb = stb_q;
  assign o_wb_we  = out_q.we;
  assign o_wb_adr = out_q.adr;
  assign o_wb_dat = out_q.dat;
  assign o_wb_sel = out_q.sel;

endmodule

// File: tb/tb_wb_bus_guard.sv
module tb_wb_bus_guard;
  localparam int AW = 32, DW = 32, LGDEPTH = 4, TIMEOUT = 1023;
  localparam int SW = DW/8;
  localparam int MAXOUT = (1 << LGDEPTH) - 1;

  logic          i_clk = 1'b0;
  logic          i_reset, i_cyc, i_stb, i_we, i_wb_ack, i_wb_stall, i_wb_err;
  logic [AW-1:0] i_adr;
  logic [DW-1:0] i_dat, i_wb_data;
  logic [SW-1:0] i_sel;
  logic          o_ack, o_stall, o_err, o_wb_cyc, o_wb_stb, o_wb_we;
  logic [DW-1:0] o_data, o_wb_dat;
  logic [AW-1:0] o_wb_adr;
  logic [SW-1:0] o_wb_sel;

  always #5 i_clk = ~i_clk;

  wb_bus_guard #(.AW(AW), .DW(DW), .LGDEPTH(LGDEPTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we),
    .i_adr(i_adr), .i_dat(i_dat), .i_sel(i_sel), .o_ack(o_ack), .o_stall(o_stall),
    .o_err(o_err), .o_data(o_data), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .o_wb_we(o_wb_we), .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } req_t;
  typedef enum {M_IDLE, M_BUSY, M_ABORT} mode_t;

  mode_t         mode;
  req_t          q[$];
  int            npend, idle_cnt, slave_pend;
  logic          e_ack, e_err, e_stall;
  logic [DW-1:0] e_data;
  int            errors = 0, checks = 0;
  int            sent, acks, n;
  bit            acc;

  task automatic chk(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    npend = 0; idle_cnt = 0; slave_pend = 0;
  endtask

  task automatic model_reset();
    mode = M_IDLE; model_clear();
    e_ack = 1'b0; e_err = 1'b0; e_stall = 1'b0; e_data = '0;
  endtask

  task automatic model_step();
    bit m_acc, cnt, tmo;
    req_t r;
    m_acc = i_cyc && i_stb && !e_stall;
    r.we = i_we; r.adr = i_adr; r.dat = i_dat; r.sel = i_sel;
    if (i_wb_ack) e_data = i_wb_data;
    e_ack = 1'b0; e_err = 1'b0;
    case (mode)
      M_IDLE: if (m_acc) begin mode = M_BUSY; q.push_back(r); npend = 1; end
      M_BUSY:
        if (!i_cyc) begin
          mode = M_IDLE; model_clear();
        end else begin
          cnt = (q.size() > 0) || (npend > 0);
          tmo = cnt && !i_wb_ack && !i_wb_err && (idle_cnt + 1 >= TIMEOUT);
          if (i_wb_err || tmo) begin
            mode = M_ABORT; e_err = 1'b1; model_clear();
          end else begin
            if (i_wb_ack && npend > 0) begin
              e_ack = 1'b1; npend--;
              if (slave_pend > 0) slave_pend--;
            end
            if (q.size() > 0 && !i_wb_stall) begin q.delete(0); slave_pend++; end
            if (m_acc) begin q.push_back(r); npend++; end
            if (i_wb_ack) idle_cnt = 0;
            else if (cnt && idle_cnt < TIMEOUT) idle_cnt++;
          end
        end
      M_ABORT: if (!i_cyc) mode = M_IDLE; else if (i_stb) e_err = 1'b1;
      default: mode = M_IDLE;
    endcase
    e_stall = (mode == M_BUSY) && (q.size() == 2 || npend == MAXOUT);
  endtask

  task automatic check_outputs();
    bit showing, e_cyc;
    showing = (mode == M_BUSY) && (q.size() > 0);
    e_cyc = (mode == M_BUSY);
    chk("ack", o_ack === e_ack, 64'(o_ack), 64'(e_ack));
    chk("err", o_err === e_err, 64'(o_err), 64'(e_err));
    chk("stall", o_stall === e_stall, 64'(o_stall), 64'(e_stall));
    chk("wb_cyc", o_wb_cyc === e_cyc, 64'(o_wb_cyc), 64'(e_cyc));
    chk("wb_stb", o_wb_stb === showing, 64'(o_wb_stb), 64'(showing));
    if (showing) begin
      chk("wb_adr", o_wb_adr === q[0].adr, 64'(o_wb_adr), 64'(q[0].adr));
      chk("wb_we", o_wb_we === q[0].we, 64'(o_wb_we), 64'(q[0].we));
      chk("wb_dat", o_wb_dat === q[0].dat, 64'(o_wb_dat), 64'(q[0].dat));
      chk("wb_sel", o_wb_sel === q[0].sel, 64'(o_wb_sel), 64'(q[0].sel));
    end
    if (e_ack) chk("data", o_data === e_data, 64'(o_data), 64'(e_data));
  endtask

  task automatic check_reset(input string p);
    chk({p, "_ack"}, o_ack === 1'b0, 64'(o_ack), 64'(0));
    chk({p, "_stall"}, o_stall === 1'b0, 64'(o_stall), 64'(0));
    chk({p, "_err"}, o_err === 1'b0, 64'(o_err), 64'(0));
    chk({p, "_data"}, o_data === '0, 64'(o_data), 64'(0));
    chk({p, "_cyc"}, o_wb_cyc === 1'b0, 64'(o_wb_cyc), 64'(0));
    chk({p, "_stb"}, o_wb_stb === 1'b0, 64'(o_wb_stb), 64'(0));
    chk({p, "_we"}, o_wb_we === 1'b0, 64'(o_wb_we), 64'(0));
    chk({p, "_adr"}, o_wb_adr === '0, 64'(o_wb_adr), 64'(0));
    chk({p, "_dat"}, o_wb_dat === '0, 64'(o_wb_dat), 64'(0));
    chk({p, "_sel"}, o_wb_sel === '0, 64'(o_wb_sel), 64'(0));
  endtask

  task automatic step();
    model_step();
    @(negedge i_clk);
    check_outputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_cyc = 1'b0; i_stb = 1'b0; i_we = 1'b0; i_adr = '0; i_dat = '0;
    i_sel = '0; i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_err = 1'b0; i_wb_data = '0;
    model_reset();
    repeat (2) @(negedge i_clk);
    check_reset("rst");
    i_reset = 1'b0;
    step();

    i_cyc = 1'b1; i_stb = 1'b1; i_we = 1'b0; i_adr = 32'h10; i_sel = '1; step();
    i_stb = 1'b0; step();
    step();
    i_wb_ack = 1'b1; i_wb_data = 32'hDEADBEEF; step();
    chk("rd_ack", o_ack === 1'b1, 64'(o_ack), 64'(1));
    chk("rd_data", o_data === 32'hDEADBEEF, 64'(o_data), 64'(32'hDEADBEEF));
    step();
    chk("stray_ack", o_ack === 1'b0, 64'(o_ack), 64'(0));
    i_wb_ack = 1'b0; i_cyc = 1'b0; step();

    i_cyc = 1'b1; i_we = 1'b1; sent = 0; acks = 0;
    for (int c = 0; c < 20; c++) begin
      i_stb = (sent < 4); i_adr = AW'(32'h100 + sent*4); i_dat = DW'(32'hA000 + sent);
      i_sel = SW'(4'hF); i_wb_stall = (c < 3);
      i_wb_ack = (slave_pend > 0); i_wb_data = $urandom;
      acc = i_stb && !e_stall;
      step();
      if (acc) sent++;
      if (o_ack) acks++;
      if (c == 1) chk("burst_stall_2nd", o_stall === 1'b1, 64'(o_stall), 64'(1));
      if (acks == 4) break;
    end
    chk("burst_acks", acks === 4, 64'(acks), 64'(4));
    i_stb = 1'b0; i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_cyc = 1'b0; step();

    i_cyc = 1'b1; i_we = 1'b0; sent = 0;
    for (int c = 0; c < 40 && sent < 15; c++) begin
      i_stb = 1'b1; i_adr = AW'(32'h200 + sent); acc = !e_stall;
      step();
      if (acc) sent++;
    end
    chk("maxout_stall", o_stall === 1'b1, 64'(o_stall), 64'(1));
    i_adr = AW'(32'h200 + 15);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("held_16th", o_stall === 1'b1, 64'(o_stall), 64'(1));
    end
    i_wb_ack = 1'b1; i_wb_data = $urandom; step();
    chk("first_ack", o_ack === 1'b1, 64'(o_ack), 64'(1));
    chk("stall_release", o_stall === 1'b0, 64'(o_stall), 64'(0));
    i_wb_ack = 1'b0; step();
    i_stb = 1'b0;
    for (int c = 0; c < 60 && npend > 0; c++) begin
      i_wb_ack = (slave_pend > 0); i_wb_data = $urandom; step();
    end
    chk("drain_npend", npend === 0, 64'(npend), 64'(0));
    i_wb_ack = 1'b0; i_cyc = 1'b0; step();

    i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h300; step();
    i_stb = 1'b0; n = 0;
    while (!o_err && n < 1100) begin step(); n++; end
    chk("timeout_clks", n === TIMEOUT, 64'(n), 64'(TIMEOUT));
    chk("timeout_cyc", o_wb_cyc === 1'b0, 64'(o_wb_cyc), 64'(0));
    i_wb_ack = 1'b1; step();
    chk("late_ack", o_ack === 1'b0, 64'(o_ack), 64'(0));
    i_wb_ack = 1'b0; i_cyc = 1'b0; step();

    i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h400; step();
    i_stb = 1'b0; step();
    i_wb_ack = 1'b1; i_wb_err = 1'b1; step();
    chk("errack_err", o_err === 1'b1, 64'(o_err), 64'(1));
    chk("errack_ack", o_ack === 1'b0, 64'(o_ack), 64'(0));
    chk("errack_cyc", o_wb_cyc === 1'b0, 64'(o_wb_cyc), 64'(0));
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_stb = 1'b1; i_adr = 32'h404; step();
    chk("abort_stb_err", o_err === 1'b1, 64'(o_err), 64'(1));
    chk("abort_no_stb", o_wb_stb === 1'b0, 64'(o_wb_stb), 64'(0));
    i_stb = 1'b0; i_cyc = 1'b0; step(); step();

    i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h500; step();
    i_adr = 32'h504; step();
    i_stb = 1'b0; step();
    i_cyc = 1'b0; i_wb_ack = 1'b1; step();
    chk("drop_cyc", o_wb_cyc === 1'b0, 64'(o_wb_cyc), 64'(0));
    chk("drop_ack", o_ack === 1'b0, 64'(o_ack), 64'(0));
    chk("drop_stall", o_stall === 1'b0, 64'(o_stall), 64'(0));
    i_wb_ack = 1'b0; step();

    i_cyc = 1'b1; i_stb = 1'b1; i_wb_stall = 1'b1; i_adr = 32'h600; step();
    i_adr = 32'h604; step();
    #2 i_reset = 1'b1;
    #1 check_reset("async_rst");
    @(negedge i_clk);
    i_reset = 1'b0; i_cyc = 1'b0; i_stb = 1'b0; i_wb_stall = 1'b0;
    model_reset();
    step();

    repeat (1500) begin
      i_cyc      = ($urandom_range(0, 59) != 0);
      i_stb      = ($urandom_range(0, 2) != 0);
      i_we       = 1'($urandom);
      i_adr      = AW'($urandom);
      i_dat      = DW'($urandom);
      i_sel      = SW'($urandom);
      i_wb_stall = ($urandom_range(0, 3) == 0);
      i_wb_ack   = ((slave_pend > 0) && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 39) == 0);
      i_wb_err   = ($urandom_range(0, 99) == 0);
      i_wb_data  = DW'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
